// File: rtl/lsu_mem_port_if.sv
// rtl/lsu_mem_port_if.sv - request/response and memory-side signal bundle for lsu_mem_port
interface lsu_mem_port_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_dw;
  logic        req_sign;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        resp_timeout;
  logic        mem_en;
  logic        mem_rw;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [1:0]  dw;
  logic        data_ready;
  logic [31:0] memory;

  // Environment view: requester plus memory responder.
  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_dw, req_sign, data_ready, memory,
    input  req_ready, resp_valid, resp_rdata, resp_err, resp_timeout,
           mem_en, mem_rw, addr, wdata, dw
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_dw, req_sign, data_ready, memory,
    output req_ready, resp_valid, resp_rdata, resp_err, resp_timeout,
           mem_en, mem_rw, addr, wdata, dw
  );
endinterface

// File: rtl/lsu_mem_port.sv
// rtl/lsu_mem_port.sv - single-outstanding load/store initiator with alignment check,
// timeout and load sign/zero extension. dw encoding: 0=byte, 1=half, 2=word.
module lsu_mem_port #(
  parameter int TIMEOUT = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  lsu_mem_port_if.slave  bus
);

  localparam logic [1:0] DB = 2'd0;
  localparam logic [1:0] DH = 2'd1;
  localparam logic [1:0] DW = 2'd2;
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  state_t      state_q, state_d;
  logic        mem_en_q, mem_en_d;
  logic        mem_rw_q, mem_rw_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [1:0]  dw_q, dw_d;
  logic        sign_q, sign_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        req_ready_q, req_ready_d;
  logic        resp_valid_q, resp_valid_d;
  logic        resp_err_q, resp_err_d;
  logic        resp_timeout_q, resp_timeout_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        misaligned;

  function automatic logic [31:0] extend(input logic [31:0] m, input logic [1:0] w,
                                         input logic s);
    logic [31:0] r;
    case (w)
      DB:      r = {{24{s & m[7]}}, m[7:0]};
      DH:      r = {{16{s & m[15]}}, m[15:0]};
      default: r = m;
    endcase
    return r;
  endfunction

  assign misaligned = ((bus.req_dw == DH) && bus.req_addr[0]) ||
                      ((bus.req_dw == DW) && (bus.req_addr[1:0] != 2'b00));

  always_comb begin
    state_d        = state_q;
    mem_en_d       = 1'b0;
    mem_rw_d       = mem_rw_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    dw_d           = dw_q;
    sign_d         = sign_q;
    cnt_d          = cnt_q;
    resp_valid_d   = 1'b0;
    resp_err_d     = 1'b0;
    resp_timeout_d = 1'b0;
    resp_rdata_d   = 32'h0;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          if (misaligned) begin
            state_d      = S_DONE;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else begin
            state_d  = S_REQ;
            mem_en_d = 1'b1;
            mem_rw_d = bus.req_we;
            addr_d   = bus.req_addr;
            wdata_d  = bus.req_wdata;
            dw_d     = bus.req_dw;
            sign_d   = bus.req_sign;
          end
        end
      end
      S_REQ: begin
        if (mem_rw_q) begin
          state_d      = S_DONE;
          resp_valid_d = 1'b1;
        end else begin
          state_d = S_WAIT;
          cnt_d   = 8'd0;
        end
      end
      S_WAIT: begin
        // data_ready wins over a timeout landing in the same cycle
        if (bus.data_ready) begin
          state_d      = S_DONE;
          resp_valid_d = 1'b1;
          resp_rdata_d = extend(bus.memory, dw_q, sign_q);
        end else if (cnt_q == CNT_LAST) begin
          state_d        = S_DONE;
          resp_valid_d   = 1'b1;
          resp_timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    req_ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      mem_en_q       <= 1'b0;
      mem_rw_q       <= 1'b0;
      addr_q         <= 32'h0;
      wdata_q        <= 32'h0;
      dw_q           <= DW;
      sign_q         <= 1'b0;
      cnt_q          <= 8'd0;
      req_ready_q    <= 1'b1;
      resp_valid_q   <= 1'b0;
      resp_err_q     <= 1'b0;
      resp_timeout_q <= 1'b0;
      resp_rdata_q   <= 32'h0;
    end else begin
      state_q        <= state_d;
      mem_en_q       <= mem_en_d;
      mem_rw_q       <= mem_rw_d;
      addr_q         <= addr_d;
      wdata_q        <= wdata_d;
      dw_q           <= dw_d;
      sign_q         <= sign_d;
      cnt_q          <= cnt_d;
      req_ready_q    <= req_ready_d;
      resp_valid_q   <= resp_valid_d;
      resp_err_q     <= resp_err_d;
      resp_timeout_q <= resp_timeout_d;
      resp_rdata_q   <= resp_rdata_d;
    end
  end

  assign bus.req_ready    = req_ready_q;
  assign bus.resp_valid   = resp_valid_q;
  assign bus.resp_rdata   = resp_rdata_q;
  assign bus.resp_err     = resp_err_q;
  assign bus.resp_timeout = resp_timeout_q;
  assign bus.mem_en       = mem_en_q;
  assign bus.mem_rw       = mem_rw_q;
  assign bus.addr         = addr_q;
  assign bus.wdata        = wdata_q;
  assign bus.dw           = dw_q;

endmodule

// File: tb/tb_lsu_mem_port.sv
// tb/tb_lsu_mem_port.sv - directed self-checking bench for lsu_mem_port
module tb_lsu_mem_port;

  localparam logic [1:0] DB = 2'd0;
  localparam logic [1:0] DH = 2'd1;
  localparam logic [1:0] DW = 2'd2;
  localparam int TIMEOUT = 16;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;

  lsu_mem_port_if bus ();

  lsu_mem_port #(.TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // lat: WAIT-relative cycle in which data_ready is driven (0 = never).
  // exp_cyc: cycles from the accepting edge until resp_valid is visible.
  task automatic run_req(input string tag, input logic we, input logic [31:0] a,
                         input logic [31:0] wd, input logic [1:0] d, input logic s,
                         input int lat, input logic [31:0] md, input logic [31:0] exp_rd,
                         input logic exp_err, input logic exp_to, input int exp_cyc);
    int          cyc;
    int          en_cnt;
    int          hold_bad;
    logic        en_rw;
    logic [31:0] en_addr;
    logic [31:0] en_wdata;
    logic [1:0]  en_dw;
    cyc = 0; en_cnt = 0; hold_bad = 0;
    en_rw = 1'b0; en_addr = 32'h0; en_wdata = 32'h0; en_dw = 2'b11;
    check({tag, ".ready"}, 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_addr = a;
    bus.req_wdata = wd;   bus.req_dw = d;  bus.req_sign = s;
    tick();
    bus.req_valid = 1'b0;
    bus.req_addr  = 32'hFFFF_FFFF;
    bus.req_dw    = DB;
    cyc = 1;
    while (!bus.resp_valid && cyc < 300) begin
      if (bus.mem_en) begin
        if (en_cnt == 0) begin
          en_rw = bus.mem_rw; en_addr = bus.addr; en_wdata = bus.wdata; en_dw = bus.dw;
        end
        en_cnt++;
      end
      if (!exp_err && (bus.addr !== a || bus.dw !== d || bus.mem_rw !== we)) hold_bad++;
      bus.data_ready = (lat > 0) && (cyc == lat + 1);
      bus.memory     = bus.data_ready ? md : 32'hA5A5_5A5A;
      tick();
      cyc++;
    end
    bus.data_ready = 1'b0;
    check({tag, ".valid"},   32'(bus.resp_valid),   32'd1);
    check({tag, ".cycles"},  32'(cyc),              32'(exp_cyc));
    check({tag, ".rdata"},   bus.resp_rdata,        exp_rd);
    check({tag, ".err"},     32'(bus.resp_err),     32'(exp_err));
    check({tag, ".timeout"}, 32'(bus.resp_timeout), 32'(exp_to));
    check({tag, ".en_cnt"},  32'(en_cnt),           exp_err ? 32'd0 : 32'd1);
    if (!exp_err) begin
      check({tag, ".en_rw"},    32'(en_rw),    32'(we));
      check({tag, ".en_addr"},  en_addr,       a);
      check({tag, ".en_wdata"}, en_wdata,      wd);
      check({tag, ".en_dw"},    32'(en_dw),    32'(d));
      check({tag, ".hold"},     32'(hold_bad), 32'd0);
    end
    tick();
    check({tag, ".valid_drop"}, 32'(bus.resp_valid), 32'd0);
    check({tag, ".ready_back"}, 32'(bus.req_ready),  32'd1);
  endtask

  initial begin
    n_checks = 0; n_pass = 0;
    rst_n = 1'b0;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
    bus.req_dw = DW; bus.req_sign = 1'b0; bus.data_ready = 1'b0; bus.memory = 32'h0;
    tick(); tick();
    check("rst.ready",  32'(bus.req_ready),  32'd1);
    check("rst.mem_en", 32'(bus.mem_en),     32'd0);
    check("rst.mem_rw", 32'(bus.mem_rw),     32'd0);
    check("rst.addr",   bus.addr,            32'h0);
    check("rst.wdata",  bus.wdata,           32'h0);
    check("rst.dw",     32'(bus.dw),         32'(DW));
    check("rst.valid",  32'(bus.resp_valid), 32'd0);
    check("rst.rdata",  bus.resp_rdata,      32'h0);
    rst_n = 1'b1;
    tick();

    run_req("lb_neg",   1'b0, 32'h103, 32'h0,         DB, 1'b1, 2, 32'h0000_00F0, 32'hFFFF_FFF0, 1'b0, 1'b0, 4);
    run_req("lhu",      1'b0, 32'h106, 32'h0,         DH, 1'b0, 2, 32'h0000_8001, 32'h0000_8001, 1'b0, 1'b0, 4);
    run_req("sw",       1'b1, 32'h200, 32'hDEAD_BEEF, DW, 1'b0, 0, 32'h0,         32'h0,         1'b0, 1'b0, 2);
    run_req("lw_mis",   1'b0, 32'h102, 32'h0,         DW, 1'b0, 0, 32'h0,         32'h0,         1'b1, 1'b0, 1);
    run_req("lh_neg",   1'b0, 32'h10A, 32'h0,         DH, 1'b1, 2, 32'hABCD_8001, 32'hFFFF_8001, 1'b0, 1'b0, 4);
    run_req("lbu_up",   1'b0, 32'h005, 32'h0,         DB, 1'b0, 3, 32'h1234_56F0, 32'h0000_00F0, 1'b0, 1'b0, 5);
    run_req("lb_pos",   1'b0, 32'h007, 32'h0,         DB, 1'b1, 1, 32'hFFFF_FF7F, 32'h0000_007F, 1'b0, 1'b0, 3);
    run_req("lh_mis",   1'b0, 32'h107, 32'h0,         DH, 1'b1, 0, 32'h0,         32'h0,         1'b1, 1'b0, 1);
    run_req("sb_odd",   1'b1, 32'h201, 32'h0000_0055, DB, 1'b0, 0, 32'h0,         32'h0,         1'b0, 1'b0, 2);
    run_req("lw_fast",  1'b0, 32'h300, 32'h0,         DW, 1'b0, 1, 32'h89AB_CDEF, 32'h89AB_CDEF, 1'b0, 1'b0, 3);
    run_req("lw_tmo",   1'b0, 32'h400, 32'h0,         DW, 1'b0, 0, 32'h0,         32'h0,         1'b0, 1'b1, TIMEOUT + 2);

    // Late response after the timeout must not start anything.
    bus.data_ready = 1'b1; bus.memory = 32'h1111_2222;
    tick(); tick();
    check("stray.valid",  32'(bus.resp_valid), 32'd0);
    check("stray.ready",  32'(bus.req_ready),  32'd1);
    check("stray.mem_en", 32'(bus.mem_en),     32'd0);
    bus.data_ready = 1'b0;
    run_req("lw_after", 1'b0, 32'h404, 32'h0,     DW, 1'b0, 2, 32'h0BAD_F00D, 32'h0BAD_F00D, 1'b0, 1'b0, 4);

    // Asynchronous reset while waiting on a load.
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = 32'h500; bus.req_dw = DW;
    tick();
    bus.req_valid = 1'b0;
    tick(); tick();
    check("arst.pre_ready", 32'(bus.req_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    check("arst.ready",  32'(bus.req_ready),  32'd1);
    check("arst.mem_en", 32'(bus.mem_en),     32'd0);
    check("arst.addr",   bus.addr,            32'h0);
    check("arst.dw",     32'(bus.dw),         32'(DW));
    bus.data_ready = 1'b1; bus.memory = 32'h7777_7777;
    tick();
    check("arst.valid",  32'(bus.resp_valid), 32'd0);
    bus.data_ready = 1'b0;
    rst_n = 1'b1;
    tick();
    run_req("lw_post",  1'b0, 32'h504, 32'h0,     DW, 1'b0, 2, 32'hCAFE_0001, 32'hCAFE_0001, 1'b0, 1'b0, 4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
